// File: rtl/timekeeper_pkg.sv
// Shared types and constants for the timekeeper controller.
// Holds the FSM state enum, BCD field limits and a BCD increment helper.
package timekeeper_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_e;

    localparam logic [7:0] SEC_MAX   = 8'h59;
    localparam logic [7:0] MIN_MAX   = 8'h59;
    localparam logic [7:0] HR_MAX_24 = 8'h23;
    localparam logic [7:0] HR_MAX_12 = 8'h12;
    localparam logic [7:0] HR_MIN_12 = 8'h01;

    // Two-digit BCD +1; the ones digit carries at 9.
    // Caller handles the field wrap before the tens digit overflows.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability debounce and press pulse for one button.
// Ports: clk, rstn (async active-low), btn_n (raw, active-low), press (1-cycle).
module btn_debounce
    import timekeeper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 655
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    // Counter runs only while the synchronised input disagrees with
    // the accepted level; any agreement restarts the stability window.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = level_q & ~level_d;
    end

    // Released (1) is the reset level so deassertion never looks like a press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/timekeeper_ctrl.sv
// Clock-face controller: BCD time keeping, set/inc button editing, display flags.
// Ports: clk, rstn, pps, fst, btn_set_n, btn_inc_n -> hr/min/sec_bcd, blank_hr,
// blank_min, colon, pm. Define TWELVE_HOUR_EN for a 1..12 hour face with pm.
module timekeeper_ctrl
    import timekeeper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 655
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pps,
    input  logic       fst,
    input  logic       btn_set_n,
    input  logic       btn_inc_n,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       blank_hr,
    output logic       blank_min,
    output logic       colon,
    output logic       pm
);

`ifdef TWELVE_HOUR_EN
    localparam logic [7:0] HR_RESET = HR_MAX_12;
`else
    localparam logic [7:0] HR_RESET = 8'h00;
`endif

    logic       set_press;
    logic       inc_press;
    logic       tick;
    logic       pps_q;
    logic       armed_q;
    state_e     state_q;
    state_e     state_d;
    logic [7:0] hr_q;
    logic [7:0] hr_d;
    logic [7:0] min_q;
    logic [7:0] min_d;
    logic [7:0] sec_q;
    logic [7:0] sec_d;
    logic       pm_q;
    logic       pm_d;
    logic       blank_hr_q;
    logic       blank_hr_d;
    logic       blank_min_q;
    logic       blank_min_d;
    logic       colon_q;
    logic       colon_d;
    logic [7:0] hr_inc;
    logic       pm_flip;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_set (
        .clk  (clk),
        .rstn (rstn),
        .btn_n(btn_set_n),
        .press(set_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_inc (
        .clk  (clk),
        .rstn (rstn),
        .btn_n(btn_inc_n),
        .press(inc_press)
    );

    // armed_q masks the first cycle after reset so a pps that is
    // already high when rstn releases is not taken as a fresh edge.
    assign tick = pps & ~pps_q & armed_q;

`ifdef TWELVE_HOUR_EN
    assign hr_inc  = (hr_q == HR_MAX_12) ? HR_MIN_12 : bcd_inc(hr_q);
    assign pm_flip = (hr_q == 8'h11);
`else
    assign hr_inc  = (hr_q == HR_MAX_24) ? 8'h00 : bcd_inc(hr_q);
    assign pm_flip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        pm_d    = pm_q;
        unique case (state_q)
            RUN: begin
                if (set_press) begin
                    state_d = SET_HR;
                end
                if (tick) begin
                    if (sec_q == SEC_MAX) begin
                        sec_d = 8'h00;
                        if (min_q == MIN_MAX) begin
                            min_d = 8'h00;
                            hr_d  = hr_inc;
                            pm_d  = pm_q ^ pm_flip;
                        end else begin
                            min_d = bcd_inc(min_q);
                        end
                    end else begin
                        sec_d = bcd_inc(sec_q);
                    end
                end
            end
            SET_HR: begin
                // set wins over a simultaneous inc
                if (set_press) begin
                    state_d = SET_MIN;
                end else if (inc_press) begin
                    hr_d = hr_inc;
                    pm_d = pm_q ^ pm_flip;
                end
            end
            SET_MIN: begin
                if (set_press) begin
                    state_d = RUN;
                    sec_d   = 8'h00;
                end else if (inc_press) begin
                    min_d = (min_q == MIN_MAX) ? 8'h00 : bcd_inc(min_q);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        // Flags track the state being entered so they change with it.
        blank_hr_d  = (state_d == SET_HR) & ~fst;
        blank_min_d = (state_d == SET_MIN) & ~fst;
        colon_d     = (state_d == RUN) ? pps : 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pps_q       <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= RUN;
            hr_q        <= HR_RESET;
            min_q       <= 8'h00;
            sec_q       <= 8'h00;
            pm_q        <= 1'b0;
            blank_hr_q  <= 1'b0;
            blank_min_q <= 1'b0;
            colon_q     <= 1'b0;
        end else begin
            pps_q       <= pps;
            armed_q     <= 1'b1;
            state_q     <= state_d;
            hr_q        <= hr_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            pm_q        <= pm_d;
            blank_hr_q  <= blank_hr_d;
            blank_min_q <= blank_min_d;
            colon_q     <= colon_d;
        end
    end

    assign hr_bcd    = hr_q;
    assign min_bcd   = min_q;
    assign sec_bcd   = sec_q;
    assign pm        = pm_q;
    assign blank_hr  = blank_hr_q;
    assign blank_min = blank_min_q;
    assign colon     = colon_q;

endmodule

// File: tb/tb_timekeeper_ctrl.sv
// Self-checking bench for timekeeper_ctrl with DEBOUNCE_CYCLES=4.
// Reference model keeps time as integers and a mode number.
module tb_timekeeper_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pps;
    logic       fst;
    logic       btn_set_n;
    logic       btn_inc_n;
    logic [7:0] hr_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       blank_hr;
    logic       blank_min;
    logic       colon;
    logic       pm;

    int n_checks = 0;
    int n_fail   = 0;

    int hh;
    int mm;
    int ss;
    int mode;
    bit m_pm;

    always #5 clk = ~clk;

    timekeeper_ctrl #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .pps      (pps),
        .fst      (fst),
        .btn_set_n(btn_set_n),
        .btn_inc_n(btn_inc_n),
        .hr_bcd   (hr_bcd),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .blank_hr (blank_hr),
        .blank_min(blank_min),
        .colon    (colon),
        .pm       (pm)
    );

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) + (v % 10));
    endfunction

    function automatic logic [23:0] m_time();
        return {bcd(hh), bcd(mm), bcd(ss)};
    endfunction

    task automatic m_reset();
`ifdef TWELVE_HOUR_EN
        hh = 12;
`else
        hh = 0;
`endif
        mm   = 0;
        ss   = 0;
        mode = 0;
        m_pm = 1'b0;
    endtask

    task automatic m_hr_inc();
`ifdef TWELVE_HOUR_EN
        if (hh == 11) m_pm = ~m_pm;
        hh = (hh == 12) ? 1 : hh + 1;
`else
        hh = (hh + 1) % 24;
`endif
    endtask

    task automatic m_tick();
        if (mode != 0) return;
        ss++;
        if (ss == 60) begin
            ss = 0;
            mm++;
            if (mm == 60) begin
                mm = 0;
                m_hr_inc();
            end
        end
    endtask

    task automatic m_set();
        if (mode == 2) ss = 0;
        mode = (mode + 1) % 3;
    endtask

    task automatic m_inc();
        if (mode == 1) m_hr_inc();
        else if (mode == 2) mm = (mm + 1) % 60;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        pps = 1'b1;
        cyc(2);
        pps = 1'b0;
        cyc(2);
        m_tick();
    endtask

    task automatic do_press(input bit s, input bit i, input int hold);
        if (s) btn_set_n = 1'b0;
        if (i) btn_inc_n = 1'b0;
        cyc(hold);
        btn_set_n = 1'b1;
        btn_inc_n = 1'b1;
        cyc(8);
        if (hold >= 4) begin
            if (s) m_set();
            else if (i) m_inc();
        end
    endtask

    task automatic goto_time(input int h, input int m, input int s, input bit p);
        do_press(1, 0, 4);
        for (int k = 0; k < 30 && !(hh == h && m_pm == p); k++) do_press(0, 1, 4);
        do_press(1, 0, 4);
        for (int k = 0; k < 70 && mm != m; k++) do_press(0, 1, 4);
        do_press(1, 0, 4);
        for (int k = 0; k < s; k++) do_tick();
    endtask

    task automatic test_reset();
        logic [23:0] exp_t;
`ifdef TWELVE_HOUR_EN
        exp_t = 24'h120000;
`else
        exp_t = 24'h000000;
`endif
        rstn      = 1'b0;
        pps       = 1'b0;
        fst       = 1'b0;
        btn_set_n = 1'b1;
        btn_inc_n = 1'b1;
        m_reset();
        cyc(3);
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd} !== exp_t) begin
            n_fail++;
            $display("FAIL reset_time: got %h required %h", {hr_bcd, min_bcd, sec_bcd}, exp_t);
        end
        n_checks++;
        if ({blank_hr, blank_min, colon, pm} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000", {blank_hr, blank_min, colon, pm});
        end
        rstn = 1'b1;
        cyc(3);
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd} !== m_time()) begin
            n_fail++;
            $display("FAIL after_reset_time: got %h required %h", {hr_bcd, min_bcd, sec_bcd}, m_time());
        end
    endtask

    task automatic test_rollover();
        logic [23:0] exp1;
        logic [23:0] exp2;
`ifdef TWELVE_HOUR_EN
        goto_time(11, 59, 58, 1'b0);
        exp1 = 24'h115959;
        exp2 = 24'h120000;
`else
        goto_time(23, 59, 58, 1'b0);
        exp1 = 24'h235959;
        exp2 = 24'h000000;
`endif
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd} !== m_time()) begin
            n_fail++;
            $display("FAIL roll_start: got %h required %h", {hr_bcd, min_bcd, sec_bcd}, m_time());
        end
        pps = 1'b1;
        cyc(1);
        n_checks++;
        if (colon !== 1'b1) begin
            n_fail++;
            $display("FAIL run_colon_high: got %b required 1", colon);
        end
        cyc(1);
        pps = 1'b0;
        cyc(2);
        m_tick();
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd, colon} !== {exp1, 1'b0}) begin
            n_fail++;
            $display("FAIL roll_first: got %h/%b required %h/0", {hr_bcd, min_bcd, sec_bcd}, colon, exp1);
        end
        do_tick();
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd} !== exp2 || exp2 !== m_time()) begin
            n_fail++;
            $display("FAIL roll_wrap: got %h required %h", {hr_bcd, min_bcd, sec_bcd}, exp2);
        end
        n_checks++;
        if (pm !== m_pm) begin
            n_fail++;
            $display("FAIL roll_pm: got %b required %b", pm, m_pm);
        end
    endtask

    task automatic test_set_sequence();
        goto_time(10, 20, 37, 1'b0);
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd} !== m_time()) begin
            n_fail++;
            $display("FAIL seq_start: got %h required %h", {hr_bcd, min_bcd, sec_bcd}, m_time());
        end
        do_press(1, 0, 5);
        for (int k = 0; k < 3; k++) do_press(0, 1, 4);
        do_press(1, 0, 4);
        for (int k = 0; k < 45; k++) do_press(0, 1, 6);
        do_press(1, 0, 4);
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd} !== m_time()) begin
            n_fail++;
            $display("FAIL seq_end: got %h required %h", {hr_bcd, min_bcd, sec_bcd}, m_time());
        end
`ifndef TWELVE_HOUR_EN
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd} !== 24'h130500) begin
            n_fail++;
            $display("FAIL seq_const: got %h required 130500", {hr_bcd, min_bcd, sec_bcd});
        end
`endif
        n_checks++;
        if ({blank_hr, blank_min, colon} !== 3'b000) begin
            n_fail++;
            $display("FAIL seq_run_flags: got %b required 000", {blank_hr, blank_min, colon});
        end
    endtask

    task automatic test_set_hr_wrap();
        int top_h;
`ifdef TWELVE_HOUR_EN
        top_h = 12;
`else
        top_h = 23;
`endif
        do_press(1, 0, 4);
        for (int k = 0; k < 30 && hh != top_h; k++) do_press(0, 1, 4);
        n_checks++;
        if ({hr_bcd, blank_hr, blank_min, colon} !== {bcd(top_h), 3'b101}) begin
            n_fail++;
            $display("FAIL sethr_top: got %h/%b required %h/101", hr_bcd, {blank_hr, blank_min, colon}, bcd(top_h));
        end
        fst = 1'b1;
        cyc(2);
        n_checks++;
        if ({blank_hr, blank_min, colon} !== 3'b001) begin
            n_fail++;
            $display("FAIL sethr_flash: got %b required 001", {blank_hr, blank_min, colon});
        end
        fst = 1'b0;
        do_press(0, 1, 4);
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd, pm} !== {m_time(), m_pm}) begin
            n_fail++;
            $display("FAIL sethr_wrap: got %h/%b required %h/%b", {hr_bcd, min_bcd, sec_bcd}, pm, m_time(), m_pm);
        end
        do_press(1, 0, 4);
        do_press(1, 0, 4);
    endtask

    task automatic test_debounce();
        logic [7:0] h0;
        do_press(1, 0, 4);
        h0 = hr_bcd;
        for (int k = 0; k < 10; k++) begin
            btn_inc_n = (k % 2 == 0) ? 1'b0 : 1'b1;
            cyc(1);
        end
        do_press(0, 1, 4);
        n_checks++;
        if (hr_bcd !== bcd(hh) || hr_bcd === h0) begin
            n_fail++;
            $display("FAIL bounce_one: got %h required %h", hr_bcd, bcd(hh));
        end
        do_press(0, 1, 3);
        n_checks++;
        if (hr_bcd !== bcd(hh)) begin
            n_fail++;
            $display("FAIL short_none: got %h required %h", hr_bcd, bcd(hh));
        end
        do_press(0, 1, 12);
        n_checks++;
        if (hr_bcd !== bcd(hh)) begin
            n_fail++;
            $display("FAIL hold_no_repeat: got %h required %h", hr_bcd, bcd(hh));
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] h0;
        h0 = hr_bcd;
        do_press(1, 1, 5);
        n_checks++;
        if ({hr_bcd, blank_hr, blank_min, colon} !== {h0, 3'b011} || mode != 2) begin
            n_fail++;
            $display("FAIL set_wins: got %h/%b required %h/011", hr_bcd, {blank_hr, blank_min, colon}, h0);
        end
    endtask

    task automatic test_async_reset();
        logic [23:0] exp_t;
`ifdef TWELVE_HOUR_EN
        exp_t = 24'h120000;
`else
        exp_t = 24'h000000;
`endif
        do_press(0, 1, 4);
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd} !== exp_t) begin
            n_fail++;
            $display("FAIL async_time: got %h required %h", {hr_bcd, min_bcd, sec_bcd}, exp_t);
        end
        n_checks++;
        if ({blank_hr, blank_min, colon, pm} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_flags: got %b required 0000", {blank_hr, blank_min, colon, pm});
        end
        m_reset();
        cyc(1);
        pps = 1'b1;
        cyc(2);
        rstn = 1'b1;
        cyc(3);
        n_checks++;
        if ({hr_bcd, min_bcd, sec_bcd, colon} !== {exp_t, 1'b1}) begin
            n_fail++;
            $display("FAIL no_release_tick: got %h/%b required %h/1", {hr_bcd, min_bcd, sec_bcd}, colon, exp_t);
        end
        pps = 1'b0;
        cyc(2);
    endtask

    task automatic test_random();
        int op;
        logic [2:0] exp_f;
        for (int n = 0; n < 150; n++) begin
            fst = 1'($urandom_range(0, 1));
            op  = $urandom_range(0, 5);
            case (op)
                0, 1: do_tick();
                2: do_press(1, 0, $urandom_range(4, 6));
                3, 4: do_press(0, 1, $urandom_range(4, 6));
                default: do_press(1'($urandom_range(0, 1)), 1'b1, 3);
            endcase
            exp_f = {(mode == 1) & ~fst, (mode == 2) & ~fst, mode != 0};
            n_checks++;
            if ({hr_bcd, min_bcd, sec_bcd, pm} !== {m_time(), m_pm}) begin
                n_fail++;
                $display("FAIL rand_time[%0d]: got %h/%b required %h/%b", n, {hr_bcd, min_bcd, sec_bcd}, pm, m_time(), m_pm);
            end
            n_checks++;
            if ({blank_hr, blank_min, colon} !== exp_f) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: got %b required %b", n, {blank_hr, blank_min, colon}, exp_f);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_set_sequence();
        test_set_hr_wrap();
        test_debounce();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timekeeper_ctrl.md
TIMEKEEPER_CTRL -- requirements
Module: timekeeper_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 655, number of clk cycles a button must be stable to be accepted (about 20 ms at 32.768 kHz).
REQ-002 clk  input  1  32.768 kHz system clock; the same clock drives the 1 Hz divider.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 pps  input  1  1 Hz square wave from the divider, synchronous to clk.
REQ-005 fst  input  1  16 Hz square wave from the divider, synchronous to clk, used for flashing.
REQ-006 btn_set_n  input  1  raw mode button, active-low, asynchronous.
REQ-007 btn_inc_n  input  1  raw increment button, active-low, asynchronous.
REQ-008 hr_bcd  output  8  hours as two BCD digits, tens in [7:4].
REQ-009 min_bcd  output  8  minutes as two BCD digits.
REQ-010 sec_bcd  output  8  seconds as two BCD digits.
REQ-011 blank_hr, blank_min  output  1 each  high = display driver blanks that field.
REQ-012 colon  output  1  colon lamp drive.
REQ-013 pm  output  1  PM indicator; constant 0 unless TWELVE_HOUR_EN is defined.

Function
REQ-014 tick SHALL be a one-cycle pulse on each pps rising edge: pps is registered once and tick = pps & ~pps_q.
REQ-015 Each button SHALL be synchronised through two flops, then debounced: the debounced level changes only after the synchronised input holds a new value for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 A press event SHALL be a one-cycle pulse on each debounced 1->0 transition; holding a button produces no repeat events.
REQ-017 The FSM SHALL have three states: RUN, SET_HR and SET_MIN.
REQ-018 FSM transitions on set_press: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN.
REQ-019 In RUN, each tick SHALL increment seconds 00..59.
- On seconds wrap 59->00, minutes increment in the same cycle.
- On minutes wrap 59->00, hours increment in the same cycle.
- Hours wrap 23->00.
REQ-020 In SET_HR, inc_press SHALL increment hours modulo the hour range, with no carry into other fields.
REQ-021 In SET_MIN, inc_press SHALL increment minutes 59->00, with no carry into hours.
REQ-022 In SET_HR and SET_MIN, ticks SHALL be ignored and seconds held.
REQ-023 On the SET_MIN->RUN transition, seconds SHALL be cleared to 00; a tick in that same cycle is discarded.
REQ-024 If set_press and inc_press occur in the same cycle, set_press SHALL win and inc_press is dropped.
REQ-025 blank_hr = (state==SET_HR) & ~fst; blank_min = (state==SET_MIN) & ~fst; both are 0 in RUN.
REQ-026 colon SHALL equal pps in RUN and be 1 in either set state.
REQ-027 All outputs SHALL be registered; a field update is visible on the outputs one cycle after the tick or press event.
REQ-028 Every counter field SHALL hold a legal BCD value at all times, and each digit carries at 9.

Reset
REQ-029 While rstn is low, the block SHALL hold:
- time 00:00:00 (12:00:00 with TWELVE_HOUR_EN);
- state RUN, pm=0, colon=0, blanks=0;
- debounce counters 0, debounced levels 1 (released), pps_q=0.
REQ-030 Reset asserted mid-setting SHALL abandon the edit immediately and discard pending press and tick events.
REQ-031 Reset deassertion SHALL NOT itself generate a tick or press event.

Configuration
REQ-032 Macro TWELVE_HOUR_EN:
- Defined: hours range 1..12; 11->12 toggles pm; 12->01 does not toggle pm. In SET_HR, the 11->12 step toggles pm and the 12->01 step wraps without toggling.
- Undefined: hours range 00..23 and pm is tied to 0.

Structure
REQ-033 Package timekeeper_pkg SHALL hold:
- the state enum (RUN, SET_HR, SET_MIN);
- BCD limit constants: SEC_MAX=8'h59, MIN_MAX=8'h59, HR_MAX_24=8'h23, HR_MAX_12=8'h12, HR_MIN_12=8'h01.
REQ-034 Sub-module btn_debounce SHALL provide synchroniser, debounce and press pulse for one button, parameterised by DEBOUNCE_CYCLES, and be instantiated twice.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-035 Time 23:59:58 in RUN, two pps rising edges -> 23:59:59, then 00:00:00; under TWELVE_HOUR_EN, 11:59:59 pm=0 plus one tick -> 12:00:00 pm=1.
REQ-036 btn_inc_n bouncing 1-cycle pulses for 10 cycles, then held low for 4 or more cycles -> exactly one inc_press; held low for 3 cycles -> none.
REQ-037 From 10:20:37, set, inc x3, set, inc x45, set -> 13:05:00, state RUN, no carry from minutes into hours.
REQ-038 In SET_HR: hr_bcd=8'h23 plus inc -> 8'h00; blank_hr follows ~fst and blank_min=0; colon=1.
REQ-039 set_press and inc_press in the same cycle while in SET_HR -> state SET_MIN, hours unchanged.
REQ-040 rstn pulsed low asynchronously mid-SET_MIN -> all outputs at reset values before the next clk edge and state RUN.
